uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  - 8N1 UART receiver; the receive end of the uart_tx link.
//  - Oversamples the serial line on tick_in strobes from uart_tick_generator (SAMPLE_RATE x baud).
//  - Deserialises frames LSB-first and presents each good byte with a one-cycle valid strobe.
//  - Reports framing errors; sits between the board RX pin and the command/byte consumer.
// PARAMETERS
//  SAMPLE_RATE  16  ticks per bit period; even, >= 4; must match the tick generator and uart_tx.
//  DATA_WIDTH   8   data bits per frame.
// PORTS
//  clk_in         in   1           system clock (100 MHz in target design)
//  rst_n_in       in   1           reset; asynchronous, active-low
//  tick_in        in   1           oversample strobe, 1 clk_in cycle wide
//  rx_in          in   1           raw serial line, asynchronous, idle high
//  data_out       out  DATA_WIDTH  last good byte; held until the next good byte
//  valid_out      out  1           1-cycle pulse: data_out updated this cycle
//  busy_out       out  1           high while a frame is being received
//  frame_err_out  out  1           1-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  Reset
//   - rst_n_in low forces, immediately and at any point (including mid-frame):
//     - data_out=0, valid_out=0, busy_out=0, frame_err_out=0
//     - state=IDLE, all counters=0
//     - sync flops=1
//  Synchroniser
//   - rx_in passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
//   - rx_s is evaluated only on cycles with tick_in=1; all counters advance only on tick_in.
//  State machine; counters cnt ($clog2(SAMPLE_RATE) bits) and bit_idx
//   - IDLE:  tick & rx_s=0 -> START, cnt=0.
//   - START: on each tick cnt++.
//     - At cnt==SAMPLE_RATE/2-1, if rx_s=0: -> DATA, cnt=0, bit_idx=0.
//     - At cnt==SAMPLE_RATE/2-1, if rx_s=1: glitch -> IDLE, no outputs.
//   - DATA: on each tick cnt++ (mid-bit alignment).
//     - At cnt==SAMPLE_RATE-1: shift rx_s into shreg MSB (right shift, LSB-first), cnt=0, bit_idx++.
//     - After bit DATA_WIDTH-1 is sampled: -> STOP.
//   - STOP: at cnt==SAMPLE_RATE-1, sample rx_s.
//     - rx_s=1: data_out<=shreg, valid_out=1 for one clk, -> IDLE.
//     - rx_s=0: frame_err_out=1 for one clk; data_out unchanged; -> BREAK.
//   - BREAK: wait for a tick with rx_s=1 -> IDLE.
//     - Prevents a held-low line re-triggering starts.
//  Outputs and timing
//   - busy_out = (state != IDLE); all outputs registered.
//   - Latency: valid_out rises 1 clk after the mid-stop-bit sampling tick.
//     - That is ~9.5 bit periods after the start edge, plus synchroniser delay.
//   - Back-to-back frames:
//     - Return to IDLE at mid-stop leaves a half bit to catch the next start edge.
//     - No idle gap is required.
//   - Counter wrap: cnt is cleared explicitly; it never relies on natural overflow.
//   - Tolerance: sampling stays within a bit for cumulative baud mismatch < ~+/-4.5%.
// TESTING
//  Common setup
//   - clk_in 100 MHz; uart_tick_generator at 115200 baud, SAMPLE_RATE=16.
//   - Bit-banged bit period 8680 ns unless stated.
//  T1 reset: rst_n_in=0 mid-frame
//   - All outputs 0 asynchronously, before the next clk edge.
//   - After release, the next clean frame 0x3C is received correctly.
//  T2 single frame 0x93 (8'b10010011)
//   - Exactly one valid_out pulse with data_out=0x93.
//   - busy_out high from start detection until the mid-stop tick.
//   - frame_err_out never pulses.
//  T3 back-to-back 0x93 then 0xC3, zero idle between frames
//   - Two valid_out pulses, data 0x93 then 0xC3, spaced ~86.8 us.
//  T4 glitch: rx_in low for 3 ticks (~1.6 us)
//   - busy_out returns low within 8 ticks.
//   - No valid_out, no frame_err_out.
//  T5 framing error: 0x55 with stop bit driven 0, line held low 2 bit times, then 0xA5
//   - One frame_err_out pulse; data_out keeps its previous value.
//   - No start is detected during the low hold.
//   - Then valid_out with data_out=0xA5.
//  T6 loopback: uart_tx -> uart_rx sending 0x00, 0xFF, 0x5A, and at 1.03x baud skew
//   - Received bytes match sent bytes; no errors.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver (receive end of the uart_tx link)
//
// Oversamples the serial line on tick_in strobes (SAMPLE_RATE ticks per bit).
// It finds the falling start edge and confirms the start bit at mid-bit. It then
// samples each data bit at its centre and shifts the bits in LSB-first. The stop
// bit is checked at its centre.
//
// Handshake: valid_out is a one-cycle strobe with no back-pressure. A downstream
// consumer must capture data_out in the same cycle as valid_out, or at any later
// cycle before the next valid_out, because data_out holds the last good byte.
// frame_err_out is a one-cycle strobe. data_out does not change on a framing error.
//
// Ports
//   clk_in         in   1           system clock
//   rst_n_in       in   1           asynchronous active-low reset
//   tick_in        in   1           oversample strobe, one clk_in cycle wide
//   rx_in          in   1           raw serial line, asynchronous, idles high
//   data_out       out  DATA_WIDTH  last good byte
//   valid_out      out  1           data_out updated this cycle
//   busy_out       out  1           frame in progress (state != IDLE)
//   frame_err_out  out  1           stop bit sampled low
//   dbg_state_out  out  3           current FSM state, for observation only
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int SAMPLE_RATE = 16,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  tick_in,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  busy_out,
  output logic                  frame_err_out,
  output logic [2:0]            dbg_state_out
);

  localparam int CW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLE_RATE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Two-flop synchroniser. It resets to the idle (high) line level, so leaving
  // reset does not look like a start edge.
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  // Registered state
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_busy;

  // Next-state values
  state_t                w_state_nx;
  logic [CW-1:0]         w_cnt_nx;
  logic [BW-1:0]         w_bit_idx_nx;
  logic [DATA_WIDTH-1:0] w_shreg_nx;
  logic [DATA_WIDTH-1:0] w_data_nx;
  logic                  w_valid_nx;
  logic                  w_ferr_nx;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_bit_idx_nx = r_bit_idx;
    w_shreg_nx   = r_shreg;
    w_data_nx    = r_data;
    w_valid_nx   = 1'b0;
    w_ferr_nx    = 1'b0;

    // Nothing moves between ticks. The counter is always cleared explicitly at
    // its terminal value and never wraps on its own.
    if (tick_in) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_nx = S_START;
            w_cnt_nx   = '0;
          end
        end

        S_START: begin
          if (r_cnt == CNT_HALF) begin
            w_cnt_nx = '0;
            if (!w_rx_s) begin
              // The line is still low at mid start bit, so this is a real start.
              // From here on, each full bit count lands on a bit centre.
              w_state_nx   = S_DATA;
              w_bit_idx_nx = '0;
            end else begin
              // A short low pulse (a glitch). Drop it without any outputs.
              w_state_nx = S_IDLE;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == CNT_FULL) begin
            w_cnt_nx = '0;
            // Right shift: the first bit received ends up in the LSB.
            w_shreg_nx = {w_rx_s, r_shreg[DATA_WIDTH-1:1]};
            if (r_bit_idx == BIT_LAST) begin
              w_state_nx   = S_STOP;
              w_bit_idx_nx = '0;
            end else begin
              w_bit_idx_nx = r_bit_idx + 1'b1;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == CNT_FULL) begin
            w_cnt_nx = '0;
            if (w_rx_s) begin
              // Go back to IDLE at mid stop bit. That leaves half a bit to catch a
              // start edge that follows with no idle gap.
              w_data_nx  = r_shreg;
              w_valid_nx = 1'b1;
              w_state_nx = S_IDLE;
            end else begin
              w_ferr_nx  = 1'b1;
              w_state_nx = S_BREAK;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          // Wait for the line to go high. A line held low must not keep
          // triggering new starts.
          if (w_rx_s) begin
            w_state_nx = S_IDLE;
          end
        end

        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_shreg   <= w_shreg_nx;
      r_data    <= w_data_nx;
      r_valid   <= w_valid_nx;
      r_ferr    <= w_ferr_nx;
      // busy is registered from the next state, so it matches (state != IDLE)
      // with no extra cycle of lag.
      r_busy    <= (w_state_nx != S_IDLE);
    end
  end

  assign data_out      = r_data;
  assign valid_out     = r_valid;
  assign frame_err_out = r_ferr;
  assign busy_out      = r_busy;
  assign dbg_state_out = r_state;

endmodule
